// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall control for the 5-stage pipeline plus interrupt flush sequencing.
// Define PIPE_HAZARD_MDU_STALL_EN to enable the mult/div busy tracker and its stalls.
module pipe_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       useRsD,
    input  logic       useRtD,
    input  logic       branchD,
    input  logic       mdUseD,
    input  logic [4:0] writeRegE,
    input  logic       regWriteE,
    input  logic       memToRegE,
    input  logic [4:0] writeRegM,
    input  logic       memToRegM,
    input  logic       mdStartE,
    input  logic       mdIsDivE,
    input  logic       int_req,
    output logic       enF,
    output logic       enD,
    output logic       clrE,
    output logic       intclr,
    output logic       md_busy,
    output logic       int_ack
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MD,
        FLUSH,
        HOLD
    } state_t;

    state_t state_q, state_d;
    logic   flush_q, flush_d;
    logic   match_e, match_m;
    logic   lw_stall, br_stall, md_stall, stall;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic match_x(
        input logic [4:0] r,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rs,
        input logic       use_rt
    );
        return (r != 5'd0) && ((use_rs && rs == r) || (use_rt && rt == r));
    endfunction

    assign match_e  = match_x(writeRegE, rsD, rtD, useRsD, useRtD);
    assign match_m  = match_x(writeRegM, rsD, rtD, useRsD, useRtD);
    assign lw_stall = memToRegE && regWriteE && match_e;
    assign br_stall = branchD && ((regWriteE && match_e) || (memToRegM && match_m));

`ifdef PIPE_HAZARD_MDU_STALL_EN
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (mdStartE) begin
            count_d = mdIsDivE ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
        end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign md_busy  = (count_q != 8'd0);
    assign md_stall = mdUseD && (md_busy || mdStartE);
`else
    logic [7:0] unused_md;
    assign unused_md = {mdUseD, mdStartE, mdIsDivE, 5'd0}
                     ^ 8'(MULT_CYCLES) ^ 8'(DIV_CYCLES);
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
`endif

    assign stall = lw_stall || br_stall || md_stall;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (int_req) begin
`ifdef PIPE_HAZARD_MDU_STALL_EN
                    state_d = md_busy ? WAIT_MD : FLUSH;
`else
                    state_d = FLUSH;
`endif
                end
            end
            WAIT_MD: if (!md_busy) state_d = FLUSH;
            FLUSH:   state_d = HOLD;
            HOLD:    if (!int_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        flush_d = (state_d == FLUSH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
        end
    end

    // The flush cycle lets the pipeline advance regardless of hazards.
    assign intclr  = flush_q;
    assign int_ack = flush_q;
    assign enF     = flush_q || !stall;
    assign enD     = flush_q || !stall;
    assign clrE    = !flush_q && stall;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles after a multiply start.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles after a divide start.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 rsD, rtD  input  5 each  source register numbers of the decode-stage instruction.
REQ-006 useRsD, useRtD  input  1 each  decode instruction reads rs / rt.
REQ-007 branchD  input  1  decode instruction is a branch/jr that compares operands in decode.
REQ-008 mdUseD  input  1  decode instruction accesses the mult/div unit (mult, div, mfhi, mflo, mthi, mtlo).
REQ-009 writeRegE  input  5  destination register in execute.
REQ-010 regWriteE, memToRegE  input  1 each  execute instruction writes a register / is a load.
REQ-011 writeRegM  input  5  destination register in memory stage.
REQ-012 memToRegM  input  1  memory-stage instruction is a load.
REQ-013 mdStartE, mdIsDivE  input  1 each  mult/div begins this cycle / operation is a divide.
REQ-014 int_req  input  1  level interrupt request from CP0.
REQ-015 enF  output  1  PC enable.
REQ-016 enD  output  1  IF/ID pipeline-register enable.
REQ-017 clrE  output  1  ID/EX bubble insert.
REQ-018 intclr  output  1  clears IF/ID, ID/EX, EX/MEM for the interrupt flush.
REQ-019 md_busy  output  1  mult/div unit occupied.
REQ-020 int_ack  output  1  one-cycle acknowledge to CP0.

Function
REQ-021 Register match SHALL require a nonzero number: matchX(r) = (r != 0) && ((useRsD && rsD == r) || (useRtD && rtD == r)).
REQ-022 lwStall SHALL be memToRegE && regWriteE && matchX(writeRegE).
REQ-023 brStall SHALL be branchD && ((regWriteE && matchX(writeRegE)) || (memToRegM && matchX(writeRegM))).
REQ-024 mdStall SHALL be mdUseD && (md_busy || mdStartE).
REQ-025 stall = lwStall || brStall || mdStall, combinational from the same cycle's inputs.
REQ-026 Outside FLUSH: enF = enD = !stall, clrE = stall, intclr = 0.
REQ-027 An 8-bit down-counter SHALL load DIV_CYCLES if mdIsDivE else MULT_CYCLES on mdStartE, otherwise decrement when nonzero; md_busy = (count != 0).
REQ-028 mdStartE at edge t SHALL give md_busy high for exactly N cycles starting after edge t.
REQ-029 mdStartE while md_busy SHALL reload the counter (restart wins over decrement).
REQ-030 Interrupt FSM states: IDLE, WAIT_MD, FLUSH, HOLD.
REQ-031 IDLE: int_req and md_busy -> WAIT_MD; int_req and !md_busy -> FLUSH; else stay.
REQ-032 WAIT_MD: normal stall logic active; -> FLUSH in the cycle after md_busy is sampled low.
REQ-033 FLUSH lasts exactly one cycle: intclr = 1, int_ack = 1, enF = enD = 1, clrE = 0, stall ignored; -> HOLD.
REQ-034 HOLD: normal stall logic active; int_req low -> IDLE; no second ack while int_req stays high.
REQ-035 int_ack SHALL be high only in FLUSH.

Reset
REQ-036 On reset: FSM = IDLE, count = 0, md_busy = 0, int_ack = 0, intclr = 0; enF/enD/clrE follow REQ-026 from inputs.
REQ-037 Reset in any state, including mid-count or FLUSH, SHALL take effect at the next edge and override all other inputs.

Configuration
REQ-038 Macro PIPE_HAZARD_MDU_STALL_EN defined: counter, md_busy, mdStall and WAIT_MD as specified.
REQ-039 Macro undefined: no counter, md_busy = 0, mdStall = 0, IDLE goes directly to FLUSH on int_req, WAIT_MD unreachable.

Verification
REQ-040 lw $3 in E (memToRegE=1, regWriteE=1, writeRegE=3), rsD=3, useRsD=1 -> enF=enD=0, clrE=1 for one cycle.
REQ-041 writeRegE=0 with all load/branch conditions otherwise matching -> enF=enD=1, clrE=0.
REQ-042 branchD=1, rtD=5, useRtD=1, memToRegM=1, writeRegM=5 -> stall=1; same with memToRegM=0 -> no stall.
REQ-043 mdStartE=1, mdIsDivE=1, then mdUseD=1 -> md_busy high 10 cycles, enD=0 during them, enD=1 the cycle after md_busy drops.
REQ-044 int_req while md_busy count=3 -> WAIT_MD 3 cycles, then one cycle intclr=int_ack=1, HOLD until int_req low; with macro undefined, FLUSH the cycle after int_req.
REQ-045 reset asserted during FLUSH and mid-count -> next cycle IDLE, md_busy=0, intclr=0.
